freq_drive_gen: RTL and testbench



---
 rtl/freq_drive_pkg.sv | 39 +++
 rtl/freq_div_seq.sv | 68 ++++++
 rtl/freq_drive_gen.sv | 150 +++++++++++++++
 tb/tb_freq_drive_gen.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/freq_drive_pkg.sv
// freq_drive_pkg: shared state types and constants for the SWIPT gate-drive generator.
// Optional macro FREQ_DRIVE_ROUND_EN selects round-to-nearest half-period.
package freq_drive_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DIVIDE,
      RUN
   } state_t;

   typedef enum logic {
      P,
      N
   } phase_t;

   localparam int unsigned FREQ_W = 20;
   localparam int unsigned DIV_W = 26;
   localparam int unsigned DCNT_W = $clog2(DIV_W);

   localparam int unsigned CLK_HZ_DEF = 100_000_000;
   localparam logic [DIV_W-1:0] CLK_HALF = DIV_W'(CLK_HZ_DEF / 2);
   localparam int unsigned FREQ_MIN_DEF = 20_000;
   localparam int unsigned FREQ_MAX_DEF = 1_000_000;
   localparam int unsigned DEAD_DEF = 10;
   localparam int unsigned HP_W_DEF = 16;

   function automatic logic [FREQ_W-1:0] clamp_freq(
      input logic [FREQ_W-1:0] f,
      input logic [FREQ_W-1:0] lo,
      input logic [FREQ_W-1:0] hi
   );
      logic [FREQ_W-1:0] r;
      r = f;
      if (f < lo) r = lo;
      if (f > hi) r = hi;
      return r;
   endfunction

endpackage

// File: rtl/freq_div_seq.sv
// freq_div_seq: restoring divider, one quotient bit per clock.
// A start while busy restarts from the new operands; abort clears everything.
module freq_div_seq
   import freq_drive_pkg::*;
#(
   parameter int unsigned Q_W = HP_W_DEF
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              start,
   input  logic              abort,
   input  logic [DIV_W-1:0]  dividend,
   input  logic [FREQ_W-1:0] divisor,
   output logic              busy,
   output logic              done,
   output logic [Q_W-1:0]    quotient
);

   logic [FREQ_W:0]   rem;
   logic [DIV_W-1:0]  q;
   logic [FREQ_W-1:0] dvs;
   logic [DCNT_W-1:0] cnt;

   logic [FREQ_W:0]   sh;
   logic [FREQ_W:0]   diff;
   logic              ge;
   logic [DIV_W-1:0]  qNx;

   // Remainder stays below the divisor, so FREQ_W+1 bits hold the shift.
   always_comb begin
      sh   = {rem[FREQ_W-1:0], q[DIV_W-1]};
      ge   = sh >= {1'b0, dvs};
      diff = sh - {1'b0, dvs};
      qNx  = {q[DIV_W-2:0], ge};
   end

   always_ff @(posedge clk) begin
      if (!nrst || abort) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         cnt      <= '0;
         rem      <= '0;
         q        <= '0;
         dvs      <= '0;
         quotient <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            rem  <= '0;
            q    <= dividend;
            dvs  <= divisor;
            cnt  <= DCNT_W'(DIV_W - 1);
            busy <= 1'b1;
         end else if (busy) begin
            rem <= ge ? diff : sh;
            q   <= qNx;
            if (cnt == '0) begin
               busy     <= 1'b0;
               done     <= 1'b1;
               quotient <= Q_W'(qNx);
            end else begin
               cnt <= cnt - DCNT_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/freq_drive_gen.sv
// freq_drive_gen: complementary bridge drive with dead time from a frequency word.
// Define FREQ_DRIVE_ROUND_EN for round-to-nearest half-period, else floor.
module freq_drive_gen
   import freq_drive_pkg::*;
#(
   parameter int unsigned CLK_HZ      = CLK_HZ_DEF,
   parameter int unsigned FREQ_MIN    = FREQ_MIN_DEF,
   parameter int unsigned FREQ_MAX    = FREQ_MAX_DEF,
   parameter int unsigned DEAD_CYCLES = DEAD_DEF,
   parameter int unsigned HP_W        = HP_W_DEF
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              swiptAlive,
   input  logic [FREQ_W-1:0] freq,
   output logic              driveP,
   output logic              driveN,
   output logic [FREQ_W-1:0] freqApplied,
   output logic              locked,
   output logic              divBusy
);

   localparam logic [DIV_W-1:0]  HALF = DIV_W'(CLK_HZ / 2);
   localparam logic [FREQ_W-1:0] FMIN = FREQ_W'(FREQ_MIN);
   localparam logic [FREQ_W-1:0] FMAX = FREQ_W'(FREQ_MAX);

   state_t            state;
   phase_t            phase;
   phase_t            phNx;
   logic [HP_W-1:0]   cnt;
   logic [HP_W-1:0]   hp;
   logic [HP_W-1:0]   pendHp;
   logic [HP_W-1:0]   qHp;
   logic [HP_W-1:0]   hpNx;
   logic [HP_W-1:0]   cntNx;
   logic [FREQ_W-1:0] reqReg;
   logic [FREQ_W-1:0] divFc;
   logic [FREQ_W-1:0] pendFc;
   logic [FREQ_W-1:0] fcNew;
   logic [DIV_W-1:0]  dividend;
   logic              pending;
   logic              start;
   logic              done;
   logic              wrap;
   logic              apply;

   function automatic logic [HP_W-1:0] deff(input logic [HP_W-1:0] h);
      logic [HP_W-1:0] d;
      d = HP_W'(DEAD_CYCLES);
      if (h - HP_W'(1) < d) d = h - HP_W'(1);
      return d;
   endfunction

   assign fcNew = clamp_freq(freq, FMIN, FMAX);

`ifdef FREQ_DRIVE_ROUND_EN
   assign dividend = HALF + DIV_W'(fcNew >> 1);
`else
   assign dividend = HALF;
`endif

   // Entering from IDLE always divides; afterwards only a new request word does.
   assign start = nrst && swiptAlive
                  && (state == IDLE || freq != reqReg);

   assign locked = (state == RUN) && !divBusy && !pending;

   freq_div_seq #(
      .Q_W (HP_W)
   ) u_div (
      .clk      (clk),
      .nrst     (nrst),
      .start    (start),
      .abort    (!swiptAlive),
      .dividend (dividend),
      .divisor  (fcNew),
      .busy     (divBusy),
      .done     (done),
      .quotient (qHp)
   );

   // A request started this cycle supersedes any older pending result.
   always_comb begin
      wrap  = cnt == hp - HP_W'(1);
      apply = wrap && phase == N && pending && !start;
      hpNx  = apply ? pendHp : hp;
      cntNx = wrap ? '0 : cnt + HP_W'(1);
      phNx  = wrap ? (phase == P ? N : P) : phase;
   end

   always_ff @(posedge clk) begin
      if (!nrst || !swiptAlive) begin
         state       <= IDLE;
         phase       <= P;
         cnt         <= '0;
         hp          <= '0;
         pendHp      <= '0;
         pendFc      <= '0;
         divFc       <= '0;
         reqReg      <= '0;
         pending     <= 1'b0;
         freqApplied <= '0;
         driveP      <= 1'b0;
         driveN      <= 1'b0;
      end else begin
         reqReg <= freq;
         if (start) divFc <= fcNew;
         unique case (state)
            IDLE: begin
               state <= DIVIDE;
            end
            DIVIDE: begin
               if (done && !start) begin
                  state       <= RUN;
                  hp          <= qHp;
                  cnt         <= '0;
                  phase       <= P;
                  pending     <= 1'b0;
                  freqApplied <= divFc;
                  driveP      <= deff(qHp) == '0;
                  driveN      <= 1'b0;
               end
            end
            RUN: begin
               cnt   <= cntNx;
               phase <= phNx;
               if (apply) begin
                  hp          <= pendHp;
                  freqApplied <= pendFc;
               end
               if (start) begin
                  pending <= 1'b0;
               end else if (done) begin
                  pending <= 1'b1;
                  pendHp  <= qHp;
                  pendFc  <= divFc;
               end else if (apply) begin
                  pending <= 1'b0;
               end
               driveP <= phNx == P && cntNx >= deff(hpNx);
               driveN <= phNx == N && cntNx >= deff(hpNx);
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_freq_drive_gen.sv
// Directed bench for freq_drive_gen: expected frequency/half-period pairs
// are queued at each request and checked when the new period appears.
module tb_freq_drive_gen;

   localparam int DEAD = 10;
`ifdef FREQ_DRIVE_ROUND_EN
   localparam int HP300 = 167;
`else
   localparam int HP300 = 166;
`endif

   typedef struct {
      int f;
      int hp;
   } exp_t;

   logic        clk = 1'b0;
   logic        nrst;
   logic        swiptAlive;
   logic [19:0] freq;
   logic        driveP;
   logic        driveN;
   logic [19:0] freqApplied;
   logic        locked;
   logic        divBusy;

   int   total = 0;
   int   bad = 0;
   int   ovAll = 0;
   bit   saw110 = 1'b0;
   exp_t sb[$];

   freq_drive_gen dut (
      .clk         (clk),
      .nrst        (nrst),
      .swiptAlive  (swiptAlive),
      .freq        (freq),
      .driveP      (driveP),
      .driveN      (driveN),
      .freqApplied (freqApplied),
      .locked      (locked),
      .divBusy     (divBusy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (driveP && driveN) ovAll++;
      if (freqApplied == 20'd110000) saw110 = 1'b1;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int deff(input int hp);
      return (hp - 1 < DEAD) ? hp - 1 : DEAD;
   endfunction

   // Called on the sample where driveP has just risen; runs to the next rise.
   task automatic measure(output int hiP, output int hiN,
                          output int per, output int ov);
      logic prev;
      hiP = 0;
      hiN = 0;
      per = 0;
      ov = 0;
      forever begin
         if (driveP) hiP++;
         if (driveN) hiN++;
         if (driveP && driveN) ov++;
         per++;
         prev = driveP;
         tick;
         if ((!prev && driveP) || per >= 20000) break;
      end
   endtask

   task automatic sync_rise(input string tag);
      int n;
      logic prev;
      n = 0;
      prev = driveP;
      forever begin
         tick;
         n++;
         if ((!prev && driveP) || n >= 20000) break;
         prev = driveP;
      end
      chk({tag, "_rise"}, 32'(n < 20000), 1);
   endtask

   task automatic startup(input string tag);
      int n;
      int busy;
      n = 0;
      busy = 0;
      swiptAlive = 1'b1;
      while (n < 200) begin
         tick;
         n++;
         if (divBusy) busy++;
         if (driveP) break;
      end
      chk({tag, "_latency"}, n, 1 + 26 + 1 + DEAD);
      chk({tag, "_busy"}, busy, 26);
   endtask

   task automatic old_period(input string tag, input int hp);
      int a, b, c, d;
      measure(a, b, c, d);
      chk({tag, "_per"}, c, 2 * hp);
      chk({tag, "_hiP"}, a, hp - deff(hp));
   endtask

   task automatic check_pop(input string tag);
      exp_t e;
      int a, b, c, d;
      chk({tag, "_sbsize"}, 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_freqApplied"}, 32'(freqApplied), e.f);
         measure(a, b, c, d);
         chk({tag, "_per"}, c, 2 * e.hp);
         chk({tag, "_hiP"}, a, e.hp - deff(e.hp));
         chk({tag, "_hiN"}, b, e.hp - deff(e.hp));
         chk({tag, "_overlap"}, d, 0);
         chk({tag, "_locked"}, 32'(locked), 1);
      end
   endtask

   task automatic push(input int f, input int hp);
      exp_t e;
      e.f = f;
      e.hp = hp;
      sb.push_back(e);
   endtask

   initial begin
      int n;
      nrst = 1'b0;
      swiptAlive = 1'b0;
      freq = '0;
      repeat (3) tick;
      chk("rst_driveP", 32'(driveP), 0);
      chk("rst_driveN", 32'(driveN), 0);
      chk("rst_freqApplied", 32'(freqApplied), 0);
      chk("rst_locked", 32'(locked), 0);
      chk("rst_divBusy", 32'(divBusy), 0);
      nrst = 1'b1;
      repeat (2) tick;
      chk("idle_locked", 32'(locked), 0);

      freq = 20'd100000;
      push(100000, 500);
      startup("start100k");
      check_pop("run100k");

      freq = 20'd125000;
      push(125000, 400);
      old_period("keep500", 500);
      check_pop("run125k");

      freq = 20'd5000;
      push(20000, 2500);
      old_period("keep400", 400);
      check_pop("clampLo");

      freq = 20'd1048575;
      push(1000000, 50);
      old_period("keep2500", 2500);
      check_pop("clampHi");

      freq = 20'd100000;
      push(100000, 500);
      old_period("keep50", 50);
      check_pop("back100k");

      freq = 20'd110000;
      repeat (10) tick;
      freq = 20'd150000;
      push(150000, 333);
      sync_rise("abort");
      check_pop("abort150k");

      n = 0;
      while (!driveN && n < 5000) begin
         tick;
         n++;
      end
      chk("seekPhaseN", 32'(driveN), 1);
      freq = 20'd300000;
      repeat (3) tick;
      chk("dropBusyBefore", 32'(divBusy), 1);
      swiptAlive = 1'b0;
      tick;
      chk("drop_driveP", 32'(driveP), 0);
      chk("drop_driveN", 32'(driveN), 0);
      chk("drop_locked", 32'(locked), 0);
      chk("drop_divBusy", 32'(divBusy), 0);
      chk("drop_freqApplied", 32'(freqApplied), 0);
      repeat (5) tick;

      push(300000, HP300);
      startup("restart");
      check_pop("run300k");

      chk("noOverlap", ovAll, 0);
      chk("never110k", 32'(saw110), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
